// File: rtl/mig_if_pkg.sv
// Shared definitions for blocks that talk to the DDR controller user interface.
// Command codes, default widths and the write-back FSM state type.
package mig_if_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int ADDR_W_DEF = 27;
    localparam int DATA_W_DEF = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mig_wb_writer.sv
// Drains evicted cache lines from the write-back FIFO into the DDR controller,
// one command plus one full-line data beat per line, with sticky error flags.
module mig_wb_writer
    import mig_if_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_busy,
    input  logic                init_calib_complete,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_rdy,
    output logic [CNT_W-1:0]    wr_count,
    output logic                ovf_err,
    output logic                timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    wb_state_e           state_q, state_d;
    logic                cmd_pend_q, cmd_pend_d;
    logic                dat_pend_q, dat_pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                tmo_err_q, tmo_err_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        state_d    = state_q;
        cmd_pend_d = cmd_pend_q;
        dat_pend_d = dat_pend_q;
        addr_d     = addr_q;
        data_d     = data_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        tmo_err_d  = tmo_err_q;
        tmo_cnt_d  = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (init_calib_complete) begin
                        addr_d     = wr_addr;
                        data_d     = wr_data;
                        cmd_pend_d = 1'b1;
                        dat_pend_d = 1'b1;
                        tmo_cnt_d  = '0;
                        state_d    = ISSUE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end

            ISSUE: begin
                // A line offered now has nowhere to go; the transfer in flight is untouched.
                if (wr_en) begin
                    ovf_d = 1'b1;
                end
                cmd_pend_d = cmd_pend_q & ~app_rdy;
                dat_pend_d = dat_pend_q & ~app_wdf_rdy;
                if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (tmo_cnt_q == TMO_LAST) begin
                        tmo_err_d = 1'b1;
                    end
                end
                if (!cmd_pend_d && !dat_pend_d) begin
                    count_d = count_q + 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_pend_q <= 1'b0;
            dat_pend_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tmo_err_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_pend_q <= cmd_pend_d;
            dat_pend_q <= dat_pend_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tmo_err_q  <= tmo_err_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // The wr_en term stops the FIFO launching another line on the capture edge.
    assign wr_busy      = ~init_calib_complete | (state_q != IDLE) | wr_en;

    assign app_addr     = addr_q;
    assign app_cmd      = CMD_WRITE;
    assign app_en       = cmd_pend_q;
    assign app_wdf_data = data_q;
    assign app_wdf_wren = dat_pend_q;
    assign app_wdf_end  = dat_pend_q;
    assign app_wdf_mask = '0;
    assign wr_count     = count_q;
    assign ovf_err      = ovf_q;
    assign timeout_err  = tmo_err_q;

endmodule

// File: tb/tb_mig_wb_writer.sv
// Randomised bench for mig_wb_writer: stimulus pushes expected lines into queues,
// an independent monitor pops and compares every accepted command and data beat.
module tb_mig_wb_writer;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_busy;
    logic                init_calib_complete;
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy;
    logic [DATA_W-1:0]   app_wdf_data;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_rdy;
    logic [CNT_W-1:0]    wr_count;
    logic                ovf_err;
    logic                timeout_err;

    mig_wb_writer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(1024), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_busy(wr_busy),
        .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .wr_count(wr_count), .ovf_err(ovf_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] cmdq[$];
    logic [DATA_W-1:0] datq[$];
    logic [CNT_W-1:0]  exp_count = '0;
    bit rand_rdy = 1'b0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one line to the DUT and record what the controller should receive.
    task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cmdq.push_back(a);
        datq.push_back(d);
        exp_count = exp_count + 1'b1;
        $display("send addr=%h data=%h", a, d);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((wr_busy || cmdq.size() != 0 || datq.size() != 0) && n < budget) begin
            tick();
            #1;
            n++;
        end
        check("idle_reached", (n < budget), 1'b1);
    endtask

    // Random controller back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                app_rdy     = 1'($urandom_range(0, 1));
                app_wdf_rdy = 1'($urandom_range(0, 1));
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (app_en === 1'b1) begin
                    if (cmdq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd actual addr=%h required=no command", app_addr);
                    end else begin
                        check("cmd_addr", app_addr, cmdq[0]);
                        check("cmd_code", app_cmd, 3'b000);
                        if (app_rdy) begin
                            $display("cmd accepted addr=%h", app_addr);
                            void'(cmdq.pop_front());
                        end
                    end
                end
                if (app_wdf_wren === 1'b1) begin
                    if (datq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_data actual data=%h required=no data", app_wdf_data);
                    end else begin
                        check("wdf_data", app_wdf_data, datq[0]);
                        check("wdf_end", app_wdf_end, 1'b1);
                        check("wdf_mask", app_wdf_mask, '0);
                        if (app_wdf_rdy) begin
                            $display("data accepted data=%h", app_wdf_data);
                            void'(datq.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300us;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit busy_s;
        int idx;
        int cyc;

        rst = 1'b1; init_calib_complete = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_app_en", app_en, 1'b0);
        check("rst_wdf_wren", app_wdf_wren, 1'b0);
        check("rst_wdf_end", app_wdf_end, 1'b0);
        check("rst_app_addr", app_addr, '0);
        check("rst_wdf_data", app_wdf_data, '0);
        check("rst_wr_count", wr_count, '0);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);

        // Calibration gating.
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check("busy_uncalibrated", wr_busy, 1'b1);
        end
        tick();
        init_calib_complete = 1'b1;
        #1;
        check("busy_calib_done", wr_busy, 1'b0);

        // Single write, no back-pressure.
        tick();
        send(27'h0000123, 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF);
        #1;
        check("t0_busy", wr_busy, 1'b1);
        tick(); wr_en = 1'b0; #1;
        check("t1_app_en", app_en, 1'b1);
        check("t1_wdf_wren", app_wdf_wren, 1'b1);
        check("t1_busy", wr_busy, 1'b1);
        check("t1_count", wr_count, 16'd0);
        tick(); #1;
        check("t2_app_en", app_en, 1'b0);
        check("t2_wdf_wren", app_wdf_wren, 1'b0);
        check("t2_count", wr_count, 16'd1);
        check("t2_busy", wr_busy, 1'b0);

        // Command stall: app_rdy low for cycles t+1..t+5.
        app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        tick();
        send(27'h5A5A5A5, {4{32'h1357_9BDF}});
        tick(); wr_en = 1'b0; #1;
        check("cs_app_en_t1", app_en, 1'b1);
        check("cs_wren_t1", app_wdf_wren, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            tick(); #1;
            check("cs_app_en_held", app_en, 1'b1);
            check("cs_wren_low", app_wdf_wren, 1'b0);
            check("cs_addr_stable", app_addr, 27'h5A5A5A5);
        end
        tick(); app_rdy = 1'b1; #1;
        check("cs_app_en_t6", app_en, 1'b1);
        tick(); #1;
        check("cs_app_en_t7", app_en, 1'b0);
        check("cs_busy_t7", wr_busy, 1'b0);
        check("cs_count", wr_count, exp_count);

        // Data stall: app_wdf_rdy low for cycles t+1..t+3.
        app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        tick();
        send(27'h0ABCDEF, {4{32'h2468_ACE0}});
        tick(); wr_en = 1'b0; #1;
        check("ds_app_en_t1", app_en, 1'b1);
        check("ds_wren_t1", app_wdf_wren, 1'b1);
        for (int k = 2; k <= 3; k++) begin
            tick(); #1;
            check("ds_app_en_low", app_en, 1'b0);
            check("ds_wren_held", app_wdf_wren, 1'b1);
            check("ds_data_stable", app_wdf_data, {4{32'h2468_ACE0}});
        end
        tick(); app_wdf_rdy = 1'b1; #1;
        tick(); #1;
        check("ds_wren_done", app_wdf_wren, 1'b0);
        check("ds_busy_done", wr_busy, 1'b0);
        check("ds_count", wr_count, exp_count);

        // Back-to-back from a FIFO model with random controller back-pressure.
        rand_rdy = 1'b1;
        idx = 0; cyc = 0;
        while (idx < 8 && cyc < 3000) begin
            busy_s = wr_busy;
            tick();
            cyc++;
            if (!busy_s) begin
                a = ADDR_W'($urandom);
                d = {$urandom, $urandom, $urandom, $urandom};
                send(a, d);
                idx++;
            end else begin
                wr_en = 1'b0;
            end
            #1;
        end
        tick(); wr_en = 1'b0; #1;
        wait_idle(500);
        check("b2b_lines_sent", idx, 8);
        check("b2b_count", wr_count, exp_count);
        check("b2b_ovf", ovf_err, 1'b0);
        rand_rdy = 1'b0;
        tick();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;

        // Overflow: a second line during ISSUE is dropped.
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        tick();
        send(27'h7000001, {4{32'hCAFE_F00D}});
        tick(); wr_en = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 27'h1111111; wr_data = {4{32'hBAD0_BAD0}};
        $display("inject overflow line addr=%h", wr_addr);
        #1;
        check("ovf_busy", wr_busy, 1'b1);
        tick(); wr_en = 1'b0; #1;
        check("ovf_set", ovf_err, 1'b1);
        check("ovf_addr_kept", app_addr, 27'h7000001);
        check("ovf_data_kept", app_wdf_data, {4{32'hCAFE_F00D}});
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        wait_idle(20);
        check("ovf_count", wr_count, exp_count);

        // Timeout: command held off well past the limit.
        app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        tick();
        send(27'h3333333, {4{32'h0F0F_0F0F}});
        tick(); wr_en = 1'b0;
        for (int k = 2; k <= 1030; k++) begin
            tick(); #1;
            if (k == 1023) check("tmo_not_yet", timeout_err, 1'b0);
            if (k == 1025) check("tmo_set", timeout_err, 1'b1);
        end
        check("tmo_still_waiting", app_en, 1'b1);
        app_rdy = 1'b1;
        wait_idle(20);
        check("tmo_count", wr_count, exp_count);
        check("tmo_sticky", timeout_err, 1'b1);

        // Reset mid-ISSUE drops the line and restores reset values.
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        tick();
        send(27'h4444444, {4{32'h5555_AAAA}});
        tick(); wr_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmdq.delete();
        datq.delete();
        exp_count = '0;
        #1;
        check("mrst_app_en", app_en, 1'b0);
        check("mrst_wdf_wren", app_wdf_wren, 1'b0);
        check("mrst_wdf_end", app_wdf_end, 1'b0);
        check("mrst_addr", app_addr, '0);
        check("mrst_data", app_wdf_data, '0);
        check("mrst_count", wr_count, '0);
        check("mrst_ovf", ovf_err, 1'b0);
        check("mrst_timeout", timeout_err, 1'b0);
        check("mrst_busy", wr_busy, 1'b0);

        // Normal write after reset.
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        tick();
        send(27'h2222222, {4{32'h7777_8888}});
        tick(); wr_en = 1'b0;
        wait_idle(20);
        check("post_rst_count", wr_count, exp_count);

        // A line offered before calibration is dropped and flagged.
        init_calib_complete = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 27'h6666666; wr_data = {4{32'h9999_9999}};
        $display("inject uncalibrated line addr=%h", wr_addr);
        #1;
        check("uncal_busy", wr_busy, 1'b1);
        tick(); wr_en = 1'b0;
        tick(); #1;
        check("uncal_ovf", ovf_err, 1'b1);
        check("uncal_app_en", app_en, 1'b0);
        check("uncal_count", wr_count, exp_count);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
